// File: rtl/integral_image_buffer.sv
// integral_image_buffer
//   Builds a II_WIDTH x II_HEIGHT integral image from a raster-ordered grayscale
//   pixel stream and serves it through a fixed-latency (3 clk) random-access
//   read port.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     pix_in           grayscale pixel (unsigned PIX_W)
//     pix_valid        pixel present this cycle (no backpressure)
//     pix_sof          marks the pixel as (0,0); only meaningful with pix_valid
//     rd_addr          read address, raster index y*II_WIDTH+x
//     rd_data          signed integral value for rd_addr issued 3 cycles earlier
//     busy             frame build in progress
//     frame_done       one-cycle pulse in the cycle the final write occurs
//     frame_valid      a complete integral image is readable
//     dbg_state        FSM state (1 = BUILD)
//
//   Optional macro IIMG_DOUBLE_BUFFER_EN: two RAM banks, build writes the back
//   bank, reads use the front bank, banks swap after frame_done. Undefined
//   (default): a single bank, reads during a build see partial data.
//
//   Stream semantics: pix_valid is a one-way qualifier; the buffer accepts every
//   valid pixel (in BUILD, or any sof pixel) and there is no ready signal.
module integral_image_buffer #(
  parameter int II_WIDTH  = 160,
  parameter int II_HEIGHT = 120,
  parameter int PIX_W     = 4,
  parameter int DATA_W    = 21,
  parameter int ADDR_W    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_valid,
  output logic                     dbg_state
);
  localparam int DEPTH = II_WIDTH * II_HEIGHT;
  localparam int XW    = $clog2(II_WIDTH);
  localparam int YW    = $clog2(II_HEIGHT);
`ifdef IIMG_DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int RAM_AW = $clog2(BANKS * DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_BUILD = 1'b1} state_t;

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [DATA_W-1:0]   r_row_sum;
  logic [DATA_W-1:0]   r_col_buf [II_WIDTH];
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_front;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_s1_ok;
  logic                r_s2_ok;
  logic [DATA_W-1:0]   r_ram_q;
  logic [DATA_W-1:0]   r_ram [BANKS*DEPTH];

  logic                w_sof;
  logic                w_acc;
  logic                w_last;
  logic [XW-1:0]       w_x;
  logic [YW-1:0]       w_y;
  logic [DATA_W-1:0]   w_row;
  logic [DATA_W-1:0]   w_above;
  logic [DATA_W-1:0]   w_ii;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [RAM_AW-1:0]   w_wr_idx;
  logic [RAM_AW-1:0]   w_rd_idx;

  assign dbg_state = (r_state == S_BUILD);

  // A sof pixel overrides the current position, so a restart never needs the
  // column buffer cleared: row 0 ignores it and every later row rewrites it.
  always_comb begin
    w_sof     = pix_valid && pix_sof;
    w_acc     = w_sof || (pix_valid && (r_state == S_BUILD));
    w_x       = w_sof ? '0 : r_x;
    w_y       = w_sof ? '0 : r_y;
    w_last    = (w_x == XW'(II_WIDTH - 1)) && (w_y == YW'(II_HEIGHT - 1));
    w_row     = (w_x == '0) ? DATA_W'(pix_in) : r_row_sum + DATA_W'(pix_in);
    w_above   = (w_y == '0) ? '0 : r_col_buf[w_x];
    w_ii      = w_above + w_row;
    w_wr_addr = ADDR_W'(w_y) * ADDR_W'(II_WIDTH) + ADDR_W'(w_x);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_row_sum   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_front     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      for (int i = 0; i < II_WIDTH; i++) r_col_buf[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      r_wr_en    <= 1'b0;
      // busy drops in the cycle after the final write (frame_done cycle)
      if (frame_done) busy <= 1'b0;
`ifdef IIMG_DOUBLE_BUFFER_EN
      if (frame_done) r_front <= ~r_front;
`endif
      if (w_acc) begin
        r_col_buf[w_x] <= w_ii;
        r_row_sum      <= w_row;
        r_wr_en        <= 1'b1;
        r_wr_addr      <= w_wr_addr;
        r_wr_data      <= w_ii;
        busy           <= 1'b1;
`ifndef IIMG_DOUBLE_BUFFER_EN
        // single bank: the restart overwrites the only copy
        if (w_sof) frame_valid <= 1'b0;
`endif
        if (w_last) begin
          r_state     <= S_IDLE;
          r_x         <= '0;
          r_y         <= '0;
          frame_done  <= 1'b1;
          frame_valid <= 1'b1;
        end else begin
          r_state <= S_BUILD;
          if (w_x == XW'(II_WIDTH - 1)) begin
            r_x <= '0;
            r_y <= w_y + 1'b1;
          end else begin
            r_x <= w_x + 1'b1;
            r_y <= w_y;
          end
        end
      end
    end
  end

  // Bank select: build writes the back bank, reads use the front bank.
  always_comb begin
    w_wr_idx = RAM_AW'(r_wr_addr);
    w_rd_idx = r_s1_ok ? RAM_AW'(r_rd_addr) : '0;
`ifdef IIMG_DOUBLE_BUFFER_EN
    if (!r_front) w_wr_idx = RAM_AW'(r_wr_addr) + RAM_AW'(DEPTH);
    if (r_front && r_s1_ok) w_rd_idx = RAM_AW'(r_rd_addr) + RAM_AW'(DEPTH);
`endif
  end

  // Storage is not reset. Nonblocking read+write in one block gives read-first
  // behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (r_wr_en) r_ram[w_wr_idx] <= r_wr_data;
    r_ram_q <= r_ram[w_rd_idx];
  end

  // Read pipeline: stage 1 address, stage 2 RAM, stage 3 output register.
  // The ok flags force 0 for out-of-range addresses and reads flushed by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_s1_ok   <= 1'b0;
      r_s2_ok   <= 1'b0;
      rd_data   <= '0;
    end else begin
      r_rd_addr <= rd_addr;
      r_s1_ok   <= (rd_addr < ADDR_W'(DEPTH));
      r_s2_ok   <= r_s1_ok;
      rd_data   <= r_s2_ok ? signed'(r_ram_q) : '0;
    end
  end

endmodule

// File: tb/tb_integral_image_buffer.sv
module tb_integral_image_buffer;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int DW = 21;
  localparam int AW = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           pix_in;
  logic                 pix_valid;
  logic                 pix_sof;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_valid;
  logic                 dbg_state;

  integral_image_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_valid (frame_valid),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;

  // scoreboard: one entry per driven cycle, compared 3 cycles later
  logic [DW-1:0] exp_q[$];
  bit            chk_q[$];
  string         tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ii_exp(input int k, input int a);
    if (a >= W * H) return '0;
    return DW'(k * ((a % W) + 1) * ((a / W) + 1));
  endfunction

  // One cycle: sample at negedge, compare the entry driven 3 cycles ago,
  // then drive this cycle's inputs and push its expectation.
  task automatic step(input logic pv, input logic sof, input logic [3:0] p,
                      input logic [AW-1:0] a, input bit c, input logic [DW-1:0] e);
    logic [DW-1:0] ee;
    bit            cc;
    string         tt;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (exp_q.size() >= 3) begin
      ee = exp_q.pop_front();
      cc = chk_q.pop_front();
      tt = tag_q.pop_front();
      if (cc) check(tt, {11'b0, rd_data}, {11'b0, ee});
    end
    pix_valid = pv;
    pix_sof   = sof;
    pix_in    = p;
    rd_addr   = a;
    exp_q.push_back(e);
    chk_q.push_back(c);
    tag_q.push_back($sformatf("rd@%0d", a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, '0, 1'b0, '0);
  endtask

  task automatic rd(input int a, input int k);
    step(1'b0, 1'b0, 4'd0, AW'(a), 1'b1, ii_exp(k, a));
  endtask

  // Constant-valued frame k; pixels 0..stop-1; optional random gaps.
  task automatic stream(input int k, input bit gaps, input int stop, input bit mid_chk);
    for (int i = 0; i < stop; i++) begin
      if (gaps) begin
        for (int g = 0; g < 8 && $urandom_range(0, 7) == 0; g++) idle(1);
      end
      step(1'b1, (i == 0), 4'(k), '0, 1'b0, '0);
      if (mid_chk && i == 100) begin
        check("busy_mid_build", {31'b0, busy}, 32'd1);
        check("frame_valid_mid_build", {31'b0, frame_valid}, 32'd0);
      end
    end
  endtask

  task automatic random_reads(input int k, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(W * H, 32767))
                                       : int'($urandom_range(0, W * H - 1));
      rd(a, k);
    end
  endtask

  int fd_before;

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; rd_addr = '0;
    idle(3);
    check("reset_rd_data", {11'b0, rd_data}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_frame_valid", {31'b0, frame_valid}, 32'd0);
    check("reset_frame_done", {31'b0, frame_done}, 32'd0);
    rst = 1'b0;
    idle(2);

    // reset in the middle of a ones frame at pixel 10000
    stream(1, 1'b0, 10000, 1'b1);
    fd_before = fd_cnt;
    rst = 1'b1;
    idle(1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_frame_valid", {31'b0, frame_valid}, 32'd0);
    rst = 1'b0;
    idle(3);
    check("rst_mid_no_frame_done", fd_cnt, fd_before);

    // full all-ones frame, continuous valid
    fd_before = fd_cnt;
    stream(1, 1'b0, W * H, 1'b1);
    idle(4);
    check("ones_frame_done_count", fd_cnt, fd_before + 1);
    check("ones_busy_after", {31'b0, busy}, 32'd0);
    check("ones_frame_valid", {31'b0, frame_valid}, 32'd1);
    rd(0, 1);
    rd(8444, 1);
    rd(19199, 1);
    // classifier's six addresses back-to-back, then out-of-range
    rd(8444, 1); rd(8379, 1); rd(5244, 1); rd(5179, 1); rd(11644, 1); rd(11579, 1);
    rd(19200, 1);
    random_reads(1, 24);
    idle(4);

    // all-15 frame with random gaps
    fd_before = fd_cnt;
    stream(15, 1'b1, W * H, 1'b1);
    idle(4);
    check("f15_frame_done_count", fd_cnt, fd_before + 1);
    rd(19199, 15);
    rd(159, 15);
    random_reads(15, 24);
    idle(4);

    // mid-frame sof: ones aborted at pixel 5000, restart with value 2
    fd_before = fd_cnt;
    stream(1, 1'b0, 5000, 1'b0);
    stream(2, 1'b0, W * H, 1'b1);
    idle(4);
    check("restart_frame_done_count", fd_cnt, fd_before + 1);
    check("restart_frame_valid", {31'b0, frame_valid}, 32'd1);
    rd(0, 2);
    rd(100, 2);
    rd(4999, 2);
    rd(8444, 2);
    rd(19199, 2);
    random_reads(2, 16);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
